// File: rtl/wisard_arb_pkg.sv
// Shared types and width helpers for the wisard frame arbiter.
package wisard_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Requester id width; a single requester still needs one bit.
    function automatic int unsigned req_width(input int unsigned n_req);
        return (clog2(n_req) > 0) ? clog2(n_req) : 1;
    endfunction

    function automatic int unsigned tag_aw(input int unsigned depth);
        return clog2(depth);
    endfunction

endpackage

// File: rtl/wisard_tag_fifo.sv
// Owner-tag FIFO: records which requester owns each frame inside the core.
module wisard_tag_fifo
    import wisard_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = tag_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wisard_arbiter.sv
// Frame-level round-robin arbiter sharing one wisard core among N_REQ
// address streams, with in-order routing of class results to the frame owner.
module wisard_arbiter
    import wisard_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned N_RAMS        = 64,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned INDEX_WIDTH   = 8,
    parameter int unsigned CLASS_WIDTH   = 4,
    parameter int unsigned TAG_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0]                 s_valid,
    output logic [N_REQ-1:0]                 s_ready,
    input  logic [N_REQ*ADDRESS_WIDTH-1:0]   s_addr,
    output logic                             core_sop,
    output logic                             core_valid,
    output logic                             core_eop,
    output logic [ADDRESS_WIDTH-1:0]         core_addr,
    output logic [INDEX_WIDTH-1:0]           core_index,
    input  logic                             core_source_valid,
    input  logic [CLASS_WIDTH-1:0]           core_class_result,
    output logic [N_REQ-1:0]                 r_valid,
    output logic [CLASS_WIDTH-1:0]           r_class,
    output logic                             busy,
    output logic                             err
);

    localparam int unsigned REQ_W  = req_width(N_REQ);
    localparam int unsigned TAG_AW = tag_aw(TAG_DEPTH);
    localparam int unsigned CNT_W  = (N_RAMS > 1) ? clog2(N_RAMS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_RAMS - 1);

    arb_state_e               state_q, state_d;
    logic [REQ_W-1:0]         g_q, g_d;
    logic [REQ_W-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     core_sop_q, core_sop_d;
    logic                     core_valid_q, core_valid_d;
    logic                     core_eop_q, core_eop_d;
    logic [ADDRESS_WIDTH-1:0] core_addr_q, core_addr_d;
    logic [INDEX_WIDTH-1:0]   core_index_q, core_index_d;
    logic [N_REQ-1:0]         r_valid_q, r_valid_d;
    logic [CLASS_WIDTH-1:0]   r_class_q, r_class_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;

    logic                     tag_push;
    logic                     tag_pop;
    logic [REQ_W-1:0]         tag_head;
    logic                     tag_full;
    logic                     tag_empty;
    logic [TAG_AW:0]          tag_count;
    logic [TAG_AW:0]          occ_d;

    logic                     win_found;
    logic [REQ_W-1:0]         win_idx;
    logic [REQ_W:0]           cand_sum;
    logic [ADDRESS_WIDTH-1:0] addr_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_addr
        assign addr_arr[k] = s_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end

    wisard_tag_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (g_q),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // Round-robin search starting at rr_q, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_sum = {1'b0, rr_q} + (REQ_W+1)'(i);
            if (cand_sum >= (REQ_W+1)'(N_REQ)) cand_sum = cand_sum - (REQ_W+1)'(N_REQ);
            if (!win_found && s_valid[cand_sum[REQ_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[REQ_W-1:0];
            end
        end
    end

    assign s_ready = (state_q == ST_STREAM) ? (N_REQ'(1) << g_q) : '0;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        core_sop_d   = 1'b0;
        core_valid_d = 1'b0;
        core_eop_d   = 1'b0;
        core_addr_d  = '0;
        core_index_d = '0;
        tag_push     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found && !tag_full) begin
                    state_d = ST_STREAM;
                    g_d     = win_idx;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                if (s_valid[g_q]) begin
                    core_valid_d = 1'b1;
                    core_addr_d  = addr_arr[g_q];
                    core_index_d = INDEX_WIDTH'(cnt_q);
                    core_sop_d   = (cnt_q == '0);
                    core_eop_d   = (cnt_q == LAST_BEAT);
                    if (cnt_q == LAST_BEAT) begin
                        tag_push = 1'b1;
                        rr_d     = (g_q == REQ_W'(N_REQ - 1)) ? '0 : g_q + REQ_W'(1);
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A result with no outstanding tag is dropped and flagged.
    always_comb begin
        tag_pop   = core_source_valid & ~tag_empty;
        r_valid_d = tag_pop ? (N_REQ'(1) << tag_head) : '0;
        r_class_d = tag_pop ? core_class_result : '0;
        err_d     = err_q | (core_source_valid & tag_empty);
        occ_d     = tag_count + (TAG_AW+1)'(tag_push) - (TAG_AW+1)'(tag_pop);
        busy_d    = (state_d == ST_STREAM) || (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            rr_q         <= '0;
            cnt_q        <= '0;
            core_sop_q   <= 1'b0;
            core_valid_q <= 1'b0;
            core_eop_q   <= 1'b0;
            core_addr_q  <= '0;
            core_index_q <= '0;
            r_valid_q    <= '0;
            r_class_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            core_sop_q   <= core_sop_d;
            core_valid_q <= core_valid_d;
            core_eop_q   <= core_eop_d;
            core_addr_q  <= core_addr_d;
            core_index_q <= core_index_d;
            r_valid_q    <= r_valid_d;
            r_class_q    <= r_class_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign core_sop   = core_sop_q;
    assign core_valid = core_valid_q;
    assign core_eop   = core_eop_q;
    assign core_addr  = core_addr_q;
    assign core_index = core_index_q;
    assign r_valid    = r_valid_q;
    assign r_class    = r_class_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_wisard_arbiter.sv
// Bench for wisard_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based frame/tag model.
module tb_wisard_arbiter;

    localparam int unsigned N_REQ     = 3;
    localparam int unsigned N_RAMS    = 4;
    localparam int unsigned AW        = 16;
    localparam int unsigned IW        = 8;
    localparam int unsigned CW        = 4;
    localparam int unsigned TAG_DEPTH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_REQ-1:0]      s_valid = '0;
    logic [N_REQ-1:0]      s_ready;
    logic [N_REQ*AW-1:0]   s_addr = '0;
    logic                  core_sop, core_valid, core_eop;
    logic [AW-1:0]         core_addr;
    logic [IW-1:0]         core_index;
    logic                  core_source_valid = 1'b0;
    logic [CW-1:0]         core_class_result = '0;
    logic [N_REQ-1:0]      r_valid;
    logic [CW-1:0]         r_class;
    logic                  busy, err;

    wisard_arbiter #(
        .N_REQ(N_REQ), .N_RAMS(N_RAMS), .ADDRESS_WIDTH(AW),
        .INDEX_WIDTH(IW), .CLASS_WIDTH(CW), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .core_sop(core_sop), .core_valid(core_valid), .core_eop(core_eop),
        .core_addr(core_addr), .core_index(core_index),
        .core_source_valid(core_source_valid), .core_class_result(core_class_result),
        .r_valid(r_valid), .r_class(r_class), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: who owns the open frame, how many beats it has sent,
    // and the ordered list of frame owners still waiting for a result.
    int               m_owner = -1;
    int               m_beat  = 0;
    int               m_rr    = 0;
    int               m_tags[$];
    bit               m_err   = 1'b0;
    bit               m_init  = 1'b0;
    logic [N_REQ-1:0] e_ready = '0, e_rv = '0;
    logic             e_cv = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_busy = 1'b0;
    logic [AW-1:0]    e_addr = '0;
    logic [IW-1:0]    e_idx  = '0;
    logic [CW-1:0]    e_rc   = '0;

    bit rec = 1'b0;
    int sop_q[$];
    int res_q[$];

    task automatic model_step();
        int  k;
        bit  was_full;
        e_cv = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_addr = '0; e_idx = '0;
        e_rv = '0;   e_rc = '0;
        if (!rst_n) begin
            m_owner = -1; m_beat = 0; m_rr = 0; m_err = 1'b0;
            m_tags.delete();
        end else begin
            was_full = (m_tags.size() >= TAG_DEPTH);
            if (core_source_valid) begin
                if (m_tags.size() > 0) begin
                    k    = m_tags.pop_front();
                    e_rv = N_REQ'(1) << k;
                    e_rc = core_class_result;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_owner < 0) begin
                if (!was_full) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        k = (m_rr + i) % N_REQ;
                        if (s_valid[k]) begin
                            m_owner = k;
                            m_beat  = 0;
                            break;
                        end
                    end
                end
            end else if (s_valid[m_owner]) begin
                e_cv   = 1'b1;
                e_addr = s_addr[m_owner*AW +: AW];
                e_idx  = IW'(m_beat);
                e_sop  = (m_beat == 0);
                e_eop  = (m_beat == N_RAMS - 1);
                if (m_beat == N_RAMS - 1) begin
                    m_tags.push_back(m_owner);
                    m_rr    = (m_owner + 1) % N_REQ;
                    m_owner = -1;
                end else begin
                    m_beat++;
                end
            end
        end
        e_busy  = (m_owner >= 0) || (m_tags.size() > 0);
        e_ready = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
        m_init  = 1'b1;
    endtask

    // Inputs are stable at the falling edge and are what the next rising edge samples.
    always @(negedge clk) begin
        if (m_init) begin
            check("s_ready", 32'(s_ready), 32'(e_ready));
            check("core_valid", 32'(core_valid), 32'(e_cv));
            check("core_sop", 32'(core_sop), 32'(e_sop));
            check("core_eop", 32'(core_eop), 32'(e_eop));
            if (e_cv) begin
                check("core_addr", 32'(core_addr), 32'(e_addr));
                check("core_index", 32'(core_index), 32'(e_idx));
            end
            check("r_valid", 32'(r_valid), 32'(e_rv));
            if (e_rv != '0) check("r_class", 32'(r_class), 32'(e_rc));
            check("busy", 32'(busy), 32'(e_busy));
            check("err", 32'(err), 32'(m_err));
        end
        if (rec) begin
            if (core_valid && core_sop) sop_q.push_back(int'(core_addr >> 8));
            if (r_valid != '0) res_q.push_back(int'(r_valid) * 16 + int'(r_class));
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] v);
        s_addr[k*AW +: AW] = v;
    endtask

    task automatic do_reset(input logic [N_REQ-1:0] v);
        rst_n = 1'b0;
        s_valid = v;
        core_source_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int n_res;
    int exp_owner[4] = '{0, 1, 0, 1};
    int exp_res[4]   = '{16 + 5, 32 + 6, 16 + 7, 32 + 8};

    initial begin
        // Single frame from requester 0.
        do_reset('0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        set_addr(0, 16'h11);
        s_valid = 3'b001;
        tick();
        check("grant_ready", 32'(s_ready), 32'b001);
        for (int b = 0; b < 4; b++) begin
            set_addr(0, AW'((b + 1) * 'h11));
            tick();
            check("sf_index", 32'(core_index), 32'(b));
            check("sf_addr", 32'(core_addr), 32'((b + 1) * 'h11));
            check("sf_sop", 32'(core_sop), 32'(b == 0));
            check("sf_eop", 32'(core_eop), 32'(b == 3));
        end
        s_valid = '0;
        core_source_valid = 1'b1;
        core_class_result = 4'd3;
        tick();
        core_source_valid = 1'b0;
        check("sf_r_valid", 32'(r_valid), 32'b001);
        check("sf_r_class", 32'(r_class), 32'd3);
        tick();
        check("sf_r_valid_off", 32'(r_valid), 32'd0);
        check("sf_busy_off", 32'(busy), 32'd0);

        // Contention between requesters 0 and 1 held valid from reset.
        set_addr(0, 16'h0A0);
        set_addr(1, 16'h1A0);
        sop_q.delete();
        res_q.delete();
        rec = 1'b1;
        do_reset(3'b011);
        n_res = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (n_res < 4 && m_tags.size() > 0 && (cyc % 3) == 0) begin
                core_source_valid = 1'b1;
                core_class_result = CW'(5 + n_res);
                n_res++;
            end else begin
                core_source_valid = 1'b0;
            end
            tick();
        end
        core_source_valid = 1'b0;
        s_valid = '0;
        rec = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("cont_grant_owner", (i < sop_q.size()) ? 32'(sop_q[i]) : 32'hFF, 32'(exp_owner[i]));
            check("cont_result", (i < res_q.size()) ? 32'(res_q[i]) : 32'hFF, 32'(exp_res[i]));
        end

        // Requester 1 stalls for three cycles after beat 1.
        do_reset('0);
        set_addr(1, 16'h155);
        s_valid = 3'b010;
        tick();
        check("stall_grant", 32'(s_ready), 32'b010);
        tick();
        tick();
        check("stall_idx1", 32'(core_index), 32'd1);
        s_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_gap_valid", 32'(core_valid), 32'd0);
        end
        s_valid = 3'b010;
        tick();
        check("stall_idx2", 32'(core_index), 32'd2);
        tick();
        check("stall_idx3", 32'(core_index), 32'd3);
        check("stall_eop", 32'(core_eop), 32'd1);
        s_valid = '0;

        // Tag FIFO fills after two unanswered frames.
        do_reset('0);
        set_addr(0, 16'h0C0);
        s_valid = 3'b001;
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_grant", 32'(s_ready), 32'd0);
        end
        check("full_model_tags", 32'(m_tags.size()), 32'd2);
        core_source_valid = 1'b1;
        core_class_result = 4'd9;
        tick();
        core_source_valid = 1'b0;
        check("full_pop_no_grant", 32'(s_ready), 32'd0);
        check("full_pop_r_valid", 32'(r_valid), 32'b001);
        tick();
        check("full_regrant", 32'(s_ready), 32'b001);
        s_valid = '0;

        // Reset in the middle of a frame owned by requester 1.
        do_reset('0);
        set_addr(0, 16'h0D0);
        set_addr(1, 16'h1D0);
        s_valid = 3'b001;
        repeat (5) tick();
        s_valid = 3'b011;
        tick();
        check("mid_grant1", 32'(s_ready), 32'b010);
        repeat (3) tick();
        check("mid_idx2", 32'(core_index), 32'd2);
        rst_n = 1'b0;
        tick();
        check("mid_rst_outs", {s_ready, core_valid, core_sop, core_eop, core_addr, core_index},
              32'd0);
        check("mid_rst_res", {r_valid, r_class, busy, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_rr_reset", 32'(s_ready), 32'b001);
        tick();
        check("mid_new_sop", 32'(core_sop), 32'd1);
        check("mid_new_idx", 32'(core_index), 32'd0);
        s_valid = '0;

        // Result with nothing outstanding.
        do_reset('0);
        core_source_valid = 1'b1;
        core_class_result = 4'd7;
        tick();
        core_source_valid = 1'b0;
        check("spur_r_valid", 32'(r_valid), 32'd0);
        check("spur_err", 32'(err), 32'd1);
        repeat (5) tick();
        check("spur_err_sticky", 32'(err), 32'd1);
        do_reset('0);
        check("spur_err_cleared", 32'(err), 32'd0);

        // Random traffic, results and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N_REQ; k++) begin
                s_valid[k] = ($urandom_range(0, 3) != 0);
                set_addr(k, AW'($urandom));
            end
            core_source_valid = (m_tags.size() > 0 && $urandom_range(0, 3) == 0) ||
                                ($urandom_range(0, 199) == 0);
            core_class_result = CW'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        s_valid = '0;
        core_source_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
